// File: rtl/cache_def.sv
// Shared types for the downstream cache data store: line type, request struct, index width.
package cache_def;

  localparam int CACHE_INDEX_W = 10;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [CACHE_INDEX_W-1:0] rdindex;
    logic [CACHE_INDEX_W-1:0] wrindex;
    logic                     we;
  } cache_req_type;

endpackage

// File: rtl/dm_data_downstream.sv
// Direct-mapped 128-bit line store with one write port, one registered read port,
// per-entry valid bits and a write-first bypass for same-index read/write.
module dm_data_downstream
  import cache_def::*;
#(
  parameter int DEPTH   = 1024,
  parameter int INDEX_W = CACHE_INDEX_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  cache_req_type  data_req,
  input  cache_data_type data_write,
  output cache_data_type data_read,
  output logic           data_valid
);

  logic [INDEX_W-1:0] w_rd_idx;
  logic [INDEX_W-1:0] w_wr_idx;
  logic               w_we;
  logic               w_bypass;

  cache_data_type     r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  cache_data_type     r_mem_q;
  cache_data_type     r_wdata_q;
  logic               r_byp_q;
  logic               r_hit_q;

  assign w_rd_idx = data_req.rdindex;
  assign w_wr_idx = data_req.wrindex;
  assign w_we     = data_req.we && rst_n;
  assign w_bypass = w_we && (w_wr_idx == w_rd_idx);

  // Data array kept free of reset and read-old so it maps onto a block RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= data_write;
    end
    r_mem_q   <= r_mem[w_rd_idx];
    r_wdata_q <= data_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_byp_q <= 1'b0;
      r_hit_q <= 1'b0;
    end else begin
      if (w_we) begin
        r_valid[w_wr_idx] <= 1'b1;
      end
      r_byp_q <= w_bypass;
      r_hit_q <= w_bypass || r_valid[w_rd_idx];
    end
  end

  // Output is a pure select of registered values, so it changes only after the edge.
  always_comb begin
    data_read = '0;
    if (r_hit_q) begin
      data_read = r_byp_q ? r_wdata_q : r_mem_q;
    end
  end

  assign data_valid = r_hit_q;

endmodule

// File: tb/tb_dm_data_downstream.sv
// Directed bench for dm_data_downstream: per-cycle model compare plus literal spot checks.
module tb_dm_data_downstream;
  import cache_def::*;

  logic           clk;
  logic           rst_n;
  cache_req_type  data_req;
  cache_data_type data_write;
  cache_data_type data_read;
  logic           data_valid;

  int n_tests;
  int n_fail;

  logic [127:0] m_mem [1024];
  bit           m_val [1024];
  logic [127:0] e_data;
  logic         e_valid;

  dm_data_downstream #(.DEPTH(1024), .INDEX_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_req   (data_req),
    .data_write (data_write),
    .data_read  (data_read),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what this edge must return, from the pre-edge contents, then apply the write.
  always @(posedge clk) begin
    if (!rst_n) begin
      e_data  = '0;
      e_valid = 1'b0;
      for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
    end else begin
      if (data_req.we && data_req.wrindex == data_req.rdindex) begin
        e_data  = data_write;
        e_valid = 1'b1;
      end else begin
        e_valid = m_val[data_req.rdindex];
        e_data  = e_valid ? m_mem[data_req.rdindex] : '0;
      end
      if (data_req.we) begin
        m_mem[data_req.wrindex] = data_write;
        m_val[data_req.wrindex] = 1'b1;
      end
    end
    #1;
    n_tests++;
    if (data_read !== e_data || data_valid !== e_valid) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got data=%h valid=%b want data=%h valid=%b",
               $time, data_read, data_valid, e_data, e_valid);
    end
  end

  task automatic drive(input logic rst, input logic we, input int wi, input int ri,
                       input logic [127:0] wd);
    @(negedge clk);
    rst_n            = rst;
    data_req.we      = we;
    data_req.wrindex = wi[9:0];
    data_req.rdindex = ri[9:0];
    data_write       = wd;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [127:0] exp_d, input logic exp_v);
    n_tests++;
    if (data_read !== exp_d || data_valid !== exp_v) begin
      n_fail++;
      $display("FAIL %s got data=%h valid=%b want data=%h valid=%b",
               name, data_read, data_valid, exp_d, exp_v);
    end
  endtask

  initial begin
    logic [127:0] pat;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    data_req   = '0;
    data_write = '0;

    drive(1'b0, 1'b0, 0, 0, 128'h0);
    drive(1'b0, 1'b0, 0, 0, 128'h0);
    check("reset_out", 128'h0, 1'b0);

    drive(1'b1, 1'b0, 0, 0, 128'h0);
    check("rd_idx0_after_reset", 128'h0, 1'b0);
    drive(1'b1, 1'b0, 0, 1023, 128'h0);
    check("rd_idx1023_after_reset", 128'h0, 1'b0);

    drive(1'b1, 1'b1, 5, 0, 128'h1234);
    check("rd_idx0_during_wr5", 128'h0, 1'b0);
    drive(1'b1, 1'b0, 0, 5, 128'h0);
    check("rd_idx5", 128'h1234, 1'b1);
    drive(1'b1, 1'b0, 0, 6, 128'h0);
    check("rd_idx6_unwritten", 128'h0, 1'b0);

    drive(1'b1, 1'b1, 7, 7, 128'hABCD);
    check("write_first_idx7", 128'hABCD, 1'b1);

    drive(1'b1, 1'b1, 12, 5, 128'h7777);
    check("indep_wr12_rd5", 128'h1234, 1'b1);

    drive(1'b1, 1'b1, 3, 0, 128'h1111);
    drive(1'b1, 1'b1, 3, 0, 128'h2222);
    drive(1'b1, 1'b0, 3, 3, 128'hFFFF);
    check("overwrite_idx3", 128'h2222, 1'b1);
    drive(1'b1, 1'b0, 3, 3, 128'h5555);
    check("we0_hold_idx3", 128'h2222, 1'b1);

    pat = {4{32'hDEADBEEF}};
    drive(1'b1, 1'b1, 31, 0, pat);
    drive(1'b1, 1'b0, 0, 31, 128'h0);
    check("full_width_idx31", 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b1);

    drive(1'b1, 1'b1, 9, 0, 128'h99);
    drive(1'b1, 1'b0, 0, 9, 128'h0);
    check("rd_idx9_before_reset", 128'h99, 1'b1);
    drive(1'b0, 1'b1, 10, 9, 128'hAA);
    check("reset_cycle_out", 128'h0, 1'b0);
    drive(1'b1, 1'b0, 0, 9, 128'h0);
    check("rd_idx9_after_reset", 128'h0, 1'b0);
    drive(1'b1, 1'b0, 0, 10, 128'h0);
    check("wr_during_reset_dropped", 128'h0, 1'b0);
    drive(1'b1, 1'b0, 0, 5, 128'h0);
    check("rd_idx5_after_reset", 128'h0, 1'b0);

    drive(1'b1, 1'b1, 1023, 1023, 128'h3C);
    check("write_first_idx1023", 128'h3C, 1'b1);
    drive(1'b1, 1'b0, 0, 1023, 128'h0);
    check("rd_idx1023", 128'h3C, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_data_downstream.md
# dm_data_downstream

Direct-mapped data RAM for the downstream path. It stores one 128-bit `cache_data_type` line per index, with one synchronous write port and one registered read port. A per-entry valid bit makes never-written entries read as zero. `downstream_top` instantiates it to hold per-client cancelled-order amounts, indexed by client ID.

## Interface
Parameters:
- `DEPTH`, default 1024: number of lines; must equal 2**`INDEX_W`.
- `INDEX_W`, default 10: index width; must match the `cache_def` index fields.

Ports:
- `clk`  in  1: the only clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `data_req`  in  `cache_req_type`: fields `rdindex` [INDEX_W-1:0], `wrindex` [INDEX_W-1:0], `we` (1 bit).
- `data_write`  in  `cache_data_type` (128): line to write at `wrindex` when `we`=1.
- `data_read`  out  `cache_data_type` (128): registered line read from `rdindex`.
- `data_valid`  out  1: registered; 1 when the line returned on `data_read` has been written since reset.

## Operation
- Storage: `DEPTH` x 128-bit data array plus a `DEPTH` x 1 valid array. The data array is not reset.
- Write: on a rising edge with `rst_n`=1 and `we`=1:
  - `mem[wrindex]` <= `data_write`;
  - `valid[wrindex]` <= 1.
- `we`=0: no state change.
- Read: every rising edge with `rst_n`=1:
  - `data_read` <= `valid[rdindex]` ? `mem[rdindex]` : 0;
  - `data_valid` <= `valid[rdindex]`.
- Read-during-write to the same index in the same cycle is write-first: `data_read` returns `data_write` and `data_valid`=1.
- A write and a read to different indices in the same cycle are independent.
- Narrower users connect the low bits of `data_read` and zero-extend their payload into `data_write`. Upper bits are stored as given.
- Indices span the full `INDEX_W` range, so there is no out-of-range case.

## Timing
- Reset, on an edge with `rst_n`=0:
  - all valid bits cleared;
  - `data_read` <= 0 and `data_valid` <= 0;
  - writes are ignored during reset.
- Reset applied mid-operation takes effect on the next edge. Every line written earlier then reads as 0 with `data_valid`=0 until it is rewritten.
- Write latency: data written at edge N is visible on `data_read` after edge N+1 when read normally, or after edge N itself when read with the write-first bypass.
- Read latency: one cycle. `rdindex` sampled at edge N appears on `data_read` and `data_valid` after edge N and holds until the next edge.
- No handshake. A request is accepted on every cycle.
- A repeated write of identical data to the same index is harmless; it simply rewrites.

## Structure
- `cache_def` package holds:
  - `cache_data_type` (logic [127:0]);
  - `cache_req_type` (packed struct: `rdindex`, `wrindex`, `we`);
  - index width constant 10.
- Single module with no sub-modules. The data array is written so synthesis infers a block RAM; the valid array and the bypass mux are plain logic.

## Test plan
- Reset, then read index 0 and index 1023 -> `data_read`=0, `data_valid`=0.
- Write 0x…0000_1234 at index 5, then read index 5 on the next cycle -> `data_read`=0x…1234, `data_valid`=1 after one cycle. Reading index 6 -> 0 and `data_valid`=0.
- Same-cycle write 0xABCD to index 7 with `rdindex`=7 -> `data_read`=0xABCD and `data_valid`=1 after that edge.
- Write 0x1111 then 0x2222 to index 3 on consecutive cycles, then read -> 0x2222. Holding `we`=0 with a changing `data_write` leaves 0x2222.
- Write all 128 bits to index 31 (pattern 0xDEADBEEF repeated) -> full 128-bit readback, no truncation.
- Write index 9, assert `rst_n`=0 for one cycle, read index 9 -> 0 and `data_valid`=0. A write attempted during the reset cycle is dropped.
